cis_line_sequencer: RTL and testbench

- Line-acquisition controller for the CIS front end: decodes the quadrature encoder, converts forward motion into line triggers and sequences one sensor line per trigger.
- Per line: SI pulse, sensor pixel clock, dummy-pixel skip window and active-pixel capture window with per-pixel valid strobes.
- Sits between the encoder/sensor pins and the pixel datapath (ADC capture and line buffer); it is the only source of SIC/SCLKC timing.

---
 rtl/cis_seq_pkg.sv | 25 ++
 rtl/cis_line_sequencer_quad_step_decoder.sv | 53 +++++
 rtl/cis_line_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_cis_line_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cis_seq_pkg.sv
// Shared constants and state encoding for the CIS line sequencer.
package cis_seq_pkg;

    localparam int unsigned PIX_IDX_W      = 12;
    localparam int unsigned DEF_DUMMY_PIX  = 89;
    localparam int unsigned DEF_ACTIVE_PIX = 2592;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SI     = 2'd1;
    localparam logic [1:0] ST_DUMMY  = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SI     = ST_SI,
        DUMMY  = ST_DUMMY,
        ACTIVE = ST_ACTIVE
    } seq_state_e;

    // Quadrature pins to a 0..3 position; forward motion is A leading B.
    function automatic logic [1:0] quad_phase(input logic a, input logic b);
        return {b, a ^ b};
    endfunction

endpackage

// File: rtl/cis_line_sequencer_quad_step_decoder.sv
// Encoder front end: pin synchronizers, x4 quadrature decode and step-to-trigger division.
module quad_step_decoder
    import cis_seq_pkg::*;
#(
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enc_a,
    input  logic              enc_b,
    input  logic [STEP_W-1:0] step_div,
    output logic              trig
);

    logic [1:0]        a_sync;
    logic [1:0]        b_sync;
    logic [1:0]        phase_q;
    logic [1:0]        phase_now;
    logic [1:0]        delta;
    logic              fwd;
    logic              rev;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_lim;

    always_comb begin
        phase_now = quad_phase(a_sync[1], b_sync[1]);
        delta     = phase_now - phase_q;
        fwd       = (delta == 2'd1);
        rev       = (delta == 2'd3);
        step_lim  = (step_div == '0) ? STEP_W'(1) : step_div;
        trig      = fwd && (step_cnt >= step_lim - 1'b1);
    end

    // A two-position jump (delta == 2) is neither fwd nor rev and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync   <= '0;
            b_sync   <= '0;
            phase_q  <= '0;
            step_cnt <= '0;
        end else begin
            a_sync  <= {a_sync[0], enc_a};
            b_sync  <= {b_sync[0], enc_b};
            phase_q <= phase_now;
            if (fwd) begin
                step_cnt <= trig ? '0 : step_cnt + 1'b1;
            end else if (rev && (step_cnt != '0)) begin
                step_cnt <= step_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cis_line_sequencer.sv
// CIS line sequencer: encoder-driven line triggers, SI/pixel-clock timing and active-pixel strobes.
// Optional internal line timer enabled by defining LSEQ_FREERUN_EN.
module cis_line_sequencer
    import cis_seq_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned DUMMY_PIX  = DEF_DUMMY_PIX,
    parameter int unsigned ACTIVE_PIX = DEF_ACTIVE_PIX,
    parameter int unsigned STEP_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic [STEP_W-1:0]    step_div,
    input  logic                 free_run,
    input  logic [23:0]          free_period,
    output logic                 sic,
    output logic                 sclk,
    output logic                 pix_valid,
    output logic [PIX_IDX_W-1:0] pix_idx,
    output logic                 line_start,
    output logic                 line_end,
    output logic                 busy,
    output logic                 overrun,
    output logic [15:0]          drop_cnt
);

    localparam int unsigned          DIV_W       = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]     DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]     DIV_HALF    = DIV_W'(CLK_DIV / 2);
    localparam logic [PIX_IDX_W-1:0] DUMMY_LAST  = PIX_IDX_W'(DUMMY_PIX - 1);
    localparam logic [PIX_IDX_W-1:0] ACTIVE_LAST = PIX_IDX_W'(ACTIVE_PIX - 1);
    localparam bit                   NO_DUMMY    = (DUMMY_PIX == 0);

    seq_state_e           state;
    logic [DIV_W-1:0]     div;
    logic [DIV_W-1:0]     div_nxt;
    logic [PIX_IDX_W-1:0] cnt;
    logic                 pending;
    logic                 pending_n;
    logic                 overrun_n;
    logic [15:0]          drop_cnt_n;
    logic                 enc_trig;
    logic                 trig;
    logic                 tick;
    logic                 end_line;
    logic                 trig_ok;
    logic                 chain;
    logic                 start_idle;

    quad_step_decoder #(
        .STEP_W (STEP_W)
    ) u_dec (
        .clk      (clk),
        .rst_n    (rst_n),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .step_div (step_div),
        .trig     (enc_trig)
    );

`ifdef LSEQ_FREERUN_EN
    logic [23:0] ft_timer;
    logic [23:0] ft_lim;
    logic        ft_trig;

    always_comb begin
        ft_lim  = (free_period == '0) ? 24'd1 : free_period;
        ft_trig = free_run && (ft_timer >= ft_lim - 1'b1);
        trig    = free_run ? ft_trig : enc_trig;
    end

    // Held at 0 while free_run is low, so each rising free_run restarts the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ft_timer <= '0;
        end else if (!free_run || ft_trig) begin
            ft_timer <= '0;
        end else begin
            ft_timer <= ft_timer + 1'b1;
        end
    end
`else
    logic unused_freerun;

    always_comb begin
        unused_freerun = ^{free_run, free_period};
        trig           = enc_trig;
    end
`endif

    always_comb begin
        tick       = (div == DIV_LAST);
        div_nxt    = tick ? '0 : div + 1'b1;
        end_line   = (state == ACTIVE) && tick && (cnt == ACTIVE_LAST);
        trig_ok    = trig && enable;
        chain      = end_line && pending && enable;
        start_idle = (state == IDLE) && (pending ? enable : trig_ok);
        pending_n  = pending && !(((state == IDLE) && enable) || chain);
        overrun_n  = overrun;
        drop_cnt_n = drop_cnt;
        // A trigger in the final line cycle is treated as busy, like any other.
        if (trig_ok && !((state == IDLE) && !pending)) begin
            if (!pending) begin
                pending_n = 1'b1;
            end else begin
                overrun_n = 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt_n = drop_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div      <= '0;
            cnt      <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            pending  <= pending_n;
            overrun  <= overrun_n;
            drop_cnt <= drop_cnt_n;
            case (state)
                IDLE: begin
                    if (start_idle) begin
                        state <= SI;
                        div   <= '0;
                    end
                end
                SI: begin
                    div <= div_nxt;
                    if (tick) begin
                        cnt   <= '0;
                        state <= NO_DUMMY ? ACTIVE : DUMMY;
                    end
                end
                DUMMY: begin
                    div <= div_nxt;
                    if (tick) begin
                        if (cnt == DUMMY_LAST) begin
                            cnt   <= '0;
                            state <= ACTIVE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    div <= div_nxt;
                    if (tick) begin
                        if (cnt == ACTIVE_LAST) begin
                            cnt   <= '0;
                            state <= chain ? SI : IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        sic        = (state == SI);
        sclk       = busy && (div < DIV_HALF);
        pix_valid  = (state == ACTIVE) && (div == DIV_HALF);
        pix_idx    = pix_valid ? cnt : '0;
        line_start = (state == SI) && (div == '0);
        line_end   = pix_valid && (cnt == ACTIVE_LAST);
    end

endmodule

// File: tb/tb_cis_line_sequencer.sv
// Scoreboard bench for cis_line_sequencer: a line-level model schedules expected line starts and pixels.
module tb_cis_line_sequencer;

    localparam int     CLK_DIV = 4;
    localparam int     DUMMY   = 89;
    localparam int     ACTIVE  = 2592;
    localparam longint P       = (1 + DUMMY + ACTIVE) * CLK_DIV;
    localparam longint FIRST   = (1 + DUMMY) * CLK_DIV + CLK_DIV / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic [7:0]  step_div = 8'd4;
    logic        free_run = 1'b0;
    logic [23:0] free_period = 24'd0;
    logic        sic, sclk, pix_valid, line_start, line_end, busy, overrun;
    logic [11:0] pix_idx;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    cis_line_sequencer #(
        .CLK_DIV    (CLK_DIV),
        .DUMMY_PIX  (DUMMY),
        .ACTIVE_PIX (ACTIVE),
        .STEP_W     (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .enc_a       (enc_a),
        .enc_b       (enc_b),
        .step_div    (step_div),
        .free_run    (free_run),
        .free_period (free_period),
        .sic         (sic),
        .sclk        (sclk),
        .pix_valid   (pix_valid),
        .pix_idx     (pix_idx),
        .line_start  (line_start),
        .line_end    (line_end),
        .busy        (busy),
        .overrun     (overrun),
        .drop_cnt    (drop_cnt)
    );

    typedef struct {
        longint t;
        int     idx;
    } pix_t;

    pix_t   px_q[$];
    longint ls_q[$];
    longint cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;

    // Line-level model: every accepted line is a fixed-length window [start, start+P-1].
    longint last_start = -1;
    longint last_end   = -1;
    bit     ovr_exp    = 1'b0;
    int     drops_exp  = 0;
    int     steps      = 0;
    int     phase      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sched(input longint s);
        ls_q.push_back(s);
        for (int i = 0; i < ACTIVE; i++) px_q.push_back(pix_t'{s + FIRST + CLK_DIV * i, i});
        last_start = s;
        last_end   = s + P - 1;
    endtask

    // Trigger seen by the sequencer in cycle n.
    task automatic accept(input longint n);
        if (!enable) return;
        if (last_end < n) sched(n + 1);
        else if (last_start > n) begin
            ovr_exp = 1'b1;
            if (drops_exp < 65535) drops_exp++;
        end else sched((last_end == n) ? n + 2 : last_end + 1);
    endtask

    task automatic set_pins();
        case (phase)
            0: {enc_a, enc_b} = 2'b00;
            1: {enc_a, enc_b} = 2'b10;
            2: {enc_a, enc_b} = 2'b11;
            default: {enc_a, enc_b} = 2'b01;
        endcase
    endtask

    // One x4 encoder edge driven at a falling clock edge; the synchronizer shows it two cycles later.
    task automatic step(input bit fwd, input int gap);
        int lim;
        lim = (step_div == 8'd0) ? 1 : int'(step_div);
        if (fwd) begin
            phase = (phase + 1) % 4;
            steps++;
            set_pins();
            if (steps >= lim) begin
                steps = 0;
                accept(cyc + 2);
            end
        end else begin
            phase = (phase + 3) % 4;
            if (steps > 0) steps--;
            set_pins();
        end
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_idx(input int idx);
        int k;
        k = 0;
        while (!(pix_valid && pix_idx == 12'(idx)) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("wait_pix_idx_timeout", k, (k < 20000) ? k : -1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((ls_q.size() != 0 || px_q.size() != 0 || busy) && k < 40000) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", k, (k < 40000) ? k : -1);
        check("lines_left", ls_q.size(), 0);
        check("pixels_left", px_q.size(), 0);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_overrun"}, overrun, ovr_exp);
        check({tag, "_drop_cnt"}, drop_cnt, drops_exp);
    endtask

    // Monitor: pops expected events as the DUT presents them and checks per-cycle timing.
    longint cur_s = -1;
    always @(negedge clk) begin
        longint s;
        longint off;
        bit     in_line;
        pix_t   e;
        if (!rst_n) begin
            cur_s = -1;
        end else begin
            if (line_start) begin
                if (ls_q.size() == 0) check("line_start_unexpected", line_start, 0);
                else begin
                    s = ls_q.pop_front();
                    check("line_start_cycle", cyc, s);
                    cur_s = s;
                end
            end
            if (pix_valid) begin
                if (px_q.size() == 0) check("pix_valid_unexpected", pix_valid, 0);
                else begin
                    e = px_q.pop_front();
                    check("pix_cycle", cyc, e.t);
                    check("pix_idx", pix_idx, e.idx);
                    check("line_end", line_end, (e.idx == ACTIVE - 1) ? 1 : 0);
                end
            end else begin
                check("line_end_no_pix", line_end, 0);
            end
            in_line = (cur_s >= 0) && (cyc <= cur_s + P - 1);
            off     = cyc - cur_s;
            check("busy", busy, in_line);
            check("sic", sic, (in_line && off < CLK_DIV) ? 1 : 0);
            check("sclk", sclk, (in_line && (off % CLK_DIV) < CLK_DIV / 2) ? 1 : 0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(negedge clk);
        check("rst_sic", sic, 0);
        check("rst_sclk", sclk, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_idx", pix_idx, 0);
        check("rst_line_start", line_start, 0);
        check("rst_line_end", line_end, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // One line per four forward edges.
        step_div = 8'd4;
        for (int i = 0; i < 4; i++) step(1'b1, $urandom_range(5, 20));
        drain();

        // Backlash: reverse edges saturate at zero, trigger only on the 4th forward edge.
        for (int i = 0; i < 4; i++) step(1'b0, $urandom_range(5, 20));
        for (int i = 0; i < 3; i++) step(1'b1, $urandom_range(5, 20));
        repeat (20) @(negedge clk);
        check("no_trig_before_4th", busy, 0);
        step(1'b1, 10);
        drain();
        check_status("backlash");

        // Triggers faster than the line period: one pending, the rest dropped.
        step_div = 8'd1;
        for (int i = 0; i < 4; i++) step(1'b1, $urandom_range(2900, 3100));
        drain();
        check_status("overrun");

        // Dropping enable mid-line finishes the line and discards later triggers.
        step_div = 8'd2;
        step(1'b1, 10);
        step(1'b1, 10);
        wait_idx(1000);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1, $urandom_range(100, 500));
        drain();
        repeat (50) @(negedge clk);
        check("enable_off_busy", busy, 0);
        check_status("enable_off");
        enable = 1'b1;
        repeat (5) @(negedge clk);

        // Asynchronous reset in the middle of a line.
        step_div = 8'd1;
        step(1'b1, 10);
        wait_idx(500);
        repeat (2) @(negedge clk);
        check("pre_rst_sclk", sclk, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_sic", sic, 0);
        check("async_rst_sclk", sclk, 0);
        check("async_rst_pix_valid", pix_valid, 0);
        check("async_rst_busy", busy, 0);
        {enc_a, enc_b} = 2'b00;
        phase      = 0;
        steps      = 0;
        ls_q.delete();
        px_q.delete();
        last_start = -1;
        last_end   = -1;
        ovr_exp    = 1'b0;
        drops_exp  = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_status("post_rst");

        // Clean line after reset, followed by a random encoder walk.
        step(1'b1, 10);
        step_div = 8'($urandom_range(1, 3));
        for (int i = 0; i < 16; i++) step($urandom_range(0, 3) != 0, $urandom_range(20, 600));
        drain();
        check_status("random_walk");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
